// File: rtl/hex_keypad_scanner.sv
// 4x4 matrix keypad scanner: one column driven low per slot, per-key
// debounce on press and release, and a four-digit history of accepted codes.
module hex_keypad_scanner #(
    parameter int SCAN_DIV     = 16000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic [3:0]  KEY,
    output logic        KEY_VALID,
    output logic        KEY_DOWN,
    output logic [15:0] VALUE
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [8:0] DEB_TGT = 9'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [3:0]    row_meta;
    logic [3:0]    rows_s;
    logic [CW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    col_idx_n;
    logic [1:0]    row_idx;
    logic [1:0]    row_idx_n;
    logic [7:0]    deb_cnt;
    logic [7:0]    deb_cnt_n;
    logic [7:0]    deb_inc;
    logic          deb_done;
    logic [1:0]    first_row;
    logic          tick;
    logic          row_low;
    logic          accept;
    logic          key_down_n;
    logic [3:0]    code;

    assign tick     = (slot_cnt == SLOT_LAST);
    assign row_low  = ~rows_s[row_idx];
    assign deb_inc  = (deb_cnt == 8'hFF) ? deb_cnt : deb_cnt + 8'd1;
    assign deb_done = ({1'b0, deb_inc} >= DEB_TGT);
    assign code     = {row_idx, col_idx};

    always_comb begin
        first_row = 2'd3;
        if (!rows_s[0])
            first_row = 2'd0;
        else if (!rows_s[1])
            first_row = 2'd1;
        else if (!rows_s[2])
            first_row = 2'd2;
    end

    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        row_idx_n  = row_idx;
        deb_cnt_n  = deb_cnt;
        accept     = 1'b0;
        key_down_n = KEY_DOWN;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (&rows_s) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        row_idx_n = first_row;
                        deb_cnt_n = 8'd1;
                        state_n   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_low && deb_done) begin
                        accept     = 1'b1;
                        key_down_n = 1'b1;
                        deb_cnt_n  = 8'd0;
                        state_n    = HELD;
                    end else if (row_low) begin
                        deb_cnt_n = deb_inc;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                        deb_cnt_n = 8'd0;
                        state_n   = SCAN;
                    end
                end
                HELD: begin
                    if (!row_low) begin
                        deb_cnt_n = 8'd1;
                        state_n   = RELEASE;
                    end
                end
                RELEASE: begin
                    // A low sample here is contact bounce: fall back to HELD
                    // without a new accept.
                    if (row_low) begin
                        deb_cnt_n = 8'd0;
                        state_n   = HELD;
                    end else if (deb_done) begin
                        key_down_n = 1'b0;
                        deb_cnt_n  = 8'd0;
                        col_idx_n  = col_idx + 2'd1;
                        state_n    = SCAN;
                    end else begin
                        deb_cnt_n = deb_inc;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta  <= 4'hF;
            rows_s    <= 4'hF;
            slot_cnt  <= '0;
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            deb_cnt   <= 8'd0;
            COL       <= 4'b1110;
            KEY       <= 4'h0;
            KEY_VALID <= 1'b0;
            KEY_DOWN  <= 1'b0;
            VALUE     <= 16'h0000;
        end else begin
            row_meta  <= ROW;
            rows_s    <= row_meta;
            slot_cnt  <= tick ? '0 : slot_cnt + 1'b1;
            state     <= state_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            deb_cnt   <= deb_cnt_n;
            COL       <= ~(4'b0001 << col_idx_n);
            KEY_VALID <= accept;
            KEY_DOWN  <= key_down_n;
            if (accept) begin
                KEY   <= code;
                VALUE <= {VALUE[11:0], code};
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: a physical keypad model closes rows against
// the driven column; expected results come from press/release durations.
module tb_hex_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_down;
    logic [15:0] value;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int acc[$];

    hex_keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (
        .CLK(clk), .RST_N(rst_n), .ROW(row), .COL(col),
        .KEY(key), .KEY_VALID(key_valid), .KEY_DOWN(key_down), .VALUE(value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // key index = {row, col}; a row reads low if any closed key in it
    // sits on the column currently driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    always @(posedge clk) if (key_valid === 1'b1) pulses++;

    function automatic logic [3:0] col_code(input int c);
        logic [3:0] m;
        m = 4'b0001 << (c % 4);
        return ~m;
    endfunction

    function automatic logic [15:0] exp_value();
        logic [15:0] v;
        v = 16'h0;
        foreach (acc[i]) v = {v[11:0], acc[i][3:0]};
        return v;
    endfunction

    task automatic hold(input int n);
        repeat (8 * n) @(posedge clk);
        @(negedge clk);
    endtask

    // returns at the first negedge after the scan moves onto column c
    task automatic wait_col(input int c, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = col;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (col === col_code(c) && prev !== col_code(c)) begin
                ok = 1'b1;
                break;
            end
            prev = col;
        end
    endtask

    task automatic press_release(input int code, input int n, output bit ok);
        wait_col(code % 4, ok);
        if (!ok) return;
        keys[code] = 1'b1;
        hold(n);
        keys[code] = 1'b0;
        hold((n >= 3) ? 3 : 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (col !== 4'b1110) begin
            errors++;
            $display("FAIL reset_col got %b want 1110", col);
        end
        checks++;
        if ({key, key_valid, key_down, value} !== 22'h0) begin
            errors++;
            $display("FAIL reset_outs got key=%h kv=%b kd=%b val=%h want zeros",
                     key, key_valid, key_down, value);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int p0;
        p0 = pulses;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            checks++;
            if (col !== col_code(k / 8)) begin
                errors++;
                $display("FAIL idle_col cyc=%0d got %b want %b", k, col, col_code(k / 8));
            end
        end
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL idle_pulses got %0d want 0", pulses - p0);
        end
    endtask

    task automatic test_bounce();
        bit ok;
        int p0;
        wait_col(0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bounce_wait got timeout want col0");
            return;
        end
        p0 = pulses;
        keys[4] = 1'b1;
        hold(1);
        keys[4] = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++;
        if (col !== 4'b1110) begin
            errors++;
            $display("FAIL bounce_hold_col got %b want 1110", col);
        end
        @(negedge clk);
        checks++;
        if (col !== 4'b1101) begin
            errors++;
            $display("FAIL bounce_next_col got %b want 1101", col);
        end
        checks++;
        if (pulses != p0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL bounce_no_key got pulses=%0d kd=%b want 0 0", pulses - p0, key_down);
        end
    endtask

    task automatic test_clean_press();
        bit ok;
        int p0;
        wait_col(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL press_wait got timeout want col2");
            return;
        end
        p0 = pulses;
        keys[10] = 1'b1;
        hold(5);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL press_pulses got %0d want 1", pulses - p0);
        end
        checks++;
        if (key !== 4'hA || value !== 16'h000A || key_down !== 1'b1) begin
            errors++;
            $display("FAIL press_outs got key=%h val=%h kd=%b want a 000a 1", key, value, key_down);
        end
        keys[10] = 1'b0;
        hold(3);
        checks++;
        if (key_down !== 1'b0 || col !== 4'b0111) begin
            errors++;
            $display("FAIL press_release got kd=%b col=%b want 0 0111", key_down, col);
        end
    endtask

    task automatic test_sequence();
        bit ok;
        int p0;
        bit all_ok;
        all_ok = 1'b1;
        p0 = pulses;
        for (int k = 1; k <= 5; k++) begin
            press_release(k, 4, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL seq_wait got timeout want column reached");
        end
        checks++;
        if (pulses - p0 != 5) begin
            errors++;
            $display("FAIL seq_pulses got %0d want 5", pulses - p0);
        end
        checks++;
        if (value !== 16'h2345 || key !== 4'h5) begin
            errors++;
            $display("FAIL seq_value got val=%h key=%h want 2345 5", value, key);
        end
    endtask

    task automatic test_release_bounce();
        bit ok;
        int p0;
        wait_col(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL relb_wait got timeout want col1");
            return;
        end
        p0 = pulses;
        keys[5] = 1'b1;
        hold(3);
        keys[13] = 1'b1;
        hold(2);
        keys[13] = 1'b0;
        hold(1);
        keys[5] = 1'b0;
        hold(2);
        keys[5] = 1'b1;
        hold(1);
        keys[5] = 1'b0;
        hold(2);
        checks++;
        if (key_down !== 1'b1) begin
            errors++;
            $display("FAIL relb_early_kd got %b want 1", key_down);
        end
        hold(1);
        checks++;
        if (key_down !== 1'b0 || col !== 4'b1011) begin
            errors++;
            $display("FAIL relb_fall got kd=%b col=%b want 0 1011", key_down, col);
        end
        checks++;
        if (pulses - p0 != 1 || key !== 4'h5) begin
            errors++;
            $display("FAIL relb_pulses got %0d key=%h want 1 5", pulses - p0, key);
        end
    endtask

    task automatic test_reset_mid_debounce();
        bit ok;
        int p0;
        wait_col(0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstdeb_wait got timeout want col0");
            return;
        end
        p0 = pulses;
        keys[0] = 1'b1;
        hold(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (col !== 4'b1110 || key !== 4'h0 || key_valid !== 1'b0
            || key_down !== 1'b0 || value !== 16'h0) begin
            errors++;
            $display("FAIL rstdeb_outs got col=%b key=%h kv=%b kd=%b val=%h want 1110 0 0 0 0000",
                     col, key, key_valid, key_down, value);
        end
        @(negedge clk);
        rst_n = 1'b1;
        keys[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (col !== 4'b1110) begin
            errors++;
            $display("FAIL rstdeb_col got %b want 1110", col);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL rstdeb_pulses got %0d want 0", pulses - p0);
        end
    endtask

    task automatic test_random();
        bit ok;
        int p0;
        int code;
        int n;
        int want;
        apply_reset();
        acc.delete();
        for (int it = 0; it < 12; it++) begin
            code = $urandom_range(15);
            n = $urandom_range(5, 1);
            p0 = pulses;
            press_release(code, n, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_wait it=%0d got timeout want col%0d", it, code % 4);
                continue;
            end
            want = (n >= 3) ? 1 : 0;
            if (want == 1) acc.push_back(code);
            checks++;
            if (pulses - p0 != want) begin
                errors++;
                $display("FAIL rand_pulses it=%0d n=%0d got %0d want %0d", it, n, pulses - p0, want);
            end
            checks++;
            if (value !== exp_value()
                || key !== ((acc.size() > 0) ? 4'(acc[$]) : 4'h0)) begin
                errors++;
                $display("FAIL rand_value it=%0d got val=%h key=%h want val=%h",
                         it, value, key, exp_value());
            end
            checks++;
            if (col !== col_code(code % 4 + 1) || key_down !== 1'b0) begin
                errors++;
                $display("FAIL rand_scan it=%0d got col=%b kd=%b want %b 0",
                         it, col, key_down, col_code(code % 4 + 1));
            end
        end
    endtask

    initial begin
        keys = '0;
        rst_n = 1'b0;
        test_reset();
        test_idle();
        test_bounce();
        test_clean_press();
        test_sequence();
        test_release_bounce();
        test_reset_mid_debounce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
